crypt_dec_sched: RTL

- Scheduler and controller in front of the 3-stage pipelined decryption core.
- Accepts 128-bit ciphertext blocks from two requesters on valid/ready channels, each with its own 6-bit round-key slice.
- Arbitrates round-robin, loads the core, resets its sequencer, and runs it with Enable for a fixed latency.
- Captures the 16 result bytes and returns them with the winning requester's id.

---
 rtl/crypt_pkg.sv | 22 ++
 rtl/crypt_dec_sched_if.sv | 28 ++
 rtl/crypt_rr_arb2.sv | 24 ++
 rtl/crypt_dec_sched.sv | 121 ++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// Shared types and constants for the decryption scheduler slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package crypt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int BLK_BYTES    = 16;
    localparam int DEC_KEY_W    = 6;
    localparam int DEC_CORE_LAT = 14;

    // Byte idx (a0..d3 on the input side, w0..w15 on the output side) lives at [idx*8 +: 8].
    function automatic int byte_lsb(input int idx);
        return idx * 8;
    endfunction

endpackage

// File: rtl/crypt_dec_sched_if.sv
// Requester-side and response-side handshake bundle for crypt_dec_sched.
// Latency: none (wires only).
// Backpressure: req_ready / rsp_ready carry the valid-ready handshakes.
interface crypt_dec_sched_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 6
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_data;
    logic [2*KEY_W-1:0]  req_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_id;

    // Requesters plus the consumer of results.
    modport master (
        output req_valid, req_data, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_data, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/crypt_rr_arb2.sv
// Two-way round-robin arbiter: grant the pointed requester if valid, else the other one.
// Latency: purely combinational.
// Backpressure: none; next_ptr names the loser so the caller can alternate.
module crypt_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);

    // Priority goes to req[ptr]; the pointer moves to whoever did not win.
    always_comb begin
        grant    = 2'b00;
        next_ptr = ptr;
        if (req[ptr]) begin
            grant[ptr] = 1'b1;
            next_ptr   = ~ptr;
        end else if (req[~ptr]) begin
            grant[~ptr] = 1'b1;
            next_ptr    = ptr;
        end
    end

endmodule

// File: rtl/crypt_dec_sched.sv
// Round-robin scheduler that loads, resets and runs the pipelined decryption core per block.
// Latency: accept cycle + LOAD + CORE_LAT RUN cycles, result valid in the 16th cycle after accept.
// Backpressure: one block in flight; req_ready stays low until the response handshakes.
// Optional block counter enabled by CRYPT_DEC_SCHED_PERF_EN.
module crypt_dec_sched
    import crypt_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int KEY_W    = DEC_KEY_W,
    parameter int CORE_LAT = DEC_CORE_LAT,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    crypt_dec_sched_if.slave    bus,
    output logic [DATA_W-1:0]   core_data,
    output logic [KEY_W-1:0]    core_key,
    output logic                core_en,
    output logic                core_rst,
    input  logic [DATA_W-1:0]   core_res,
    output logic                busy,
    output logic [CNT_W-1:0]    blk_count
);

    localparam int CW = $clog2(CORE_LAT) + 1;

    state_t            state;
    logic              rr_ptr;
    logic              next_ptr;
    logic [1:0]        grant;
    logic              xfer;
    logic [CW-1:0]     cnt;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] sel_data;
    logic [KEY_W-1:0]  sel_key;

    crypt_rr_arb2 u_arb (
        .req      (bus.req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // Only the winner sees ready, and only while idle and out of reset.
    assign bus.req_ready = (state == IDLE && !reset) ? grant : 2'b00;
    assign xfer          = |(bus.req_valid & bus.req_ready);
    assign sel_data      = grant[1] ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
    assign sel_key       = grant[1] ? bus.req_key[2*KEY_W-1:KEY_W]    : bus.req_key[KEY_W-1:0];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state != IDLE);

    // Block sequencing: accept, pulse core reset, run the core CORE_LAT cycles, hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            cnt         <= '0;
            core_data   <= '0;
            core_key    <= '0;
            core_en     <= 1'b0;
            core_rst    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        core_data <= sel_data;
                        core_key  <= sel_key;
                        rsp_id_q  <= grant[1];
                        rr_ptr    <= next_ptr;
                        core_rst  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    core_rst <= 1'b0;
                    core_en  <= 1'b1;
                    cnt      <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CORE_LAT - 1)) begin
                        core_en     <= 1'b0;
                        rsp_data_q  <= core_res;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRYPT_DEC_SCHED_PERF_EN
    // Completed-block counter, saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_count <= '0;
        end else if (rsp_valid_q && bus.rsp_ready && blk_count != {CNT_W{1'b1}}) begin
            blk_count <= blk_count + 1'b1;
        end
    end
`else
    assign blk_count = '0;
`endif

endmodule
